mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_stage_mul_iter.sv | 107 ++++++++++
 rtl/mem_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: HI/LO width, multiply FSM
// state encoding and the MULT / MFHL / MTHL opcode constants.
package mem_stage_pkg;

  localparam int HILO_W = 32;
  localparam int PROD_W = 2 * HILO_W;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  localparam logic [1:0] MULT_OP_S = 2'b01;
  localparam logic [1:0] MULT_OP_U = 2'b10;
  localparam logic [1:0] MFHL_HI   = 2'b10;
  localparam logic [1:0] MFHL_LO   = 2'b01;
  localparam logic [1:0] MTHL_HI   = 2'b10;
  localparam logic [1:0] MTHL_LO   = 2'b01;

endpackage

// File: rtl/mem_stage_mul_iter.sv
// mul_iter: 32x32 -> 64-bit multiplier for MULT/MULTU.
// With ITERATIVE_MUL_EN defined it is a shift-add unit: one cycle to accept,
// 32 BUSY cycles, one DONE cycle carrying the product. Without it the product
// is combinational and done follows start in the same cycle.
module mul_iter
  import mem_stage_pkg::*;
(
`ifdef ITERATIVE_MUL_EN
  input  logic              clk_i,
  input  logic              rst_i,
`endif
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [HILO_W-1:0] a_i,
  input  logic [HILO_W-1:0] b_i,
  output logic [PROD_W-1:0] product_o,
  output logic              done_o,
  output logic              stall_o
);

`ifdef ITERATIVE_MUL_EN
  mul_state_e        state_q;
  logic [4:0]        count_q;
  logic              done_q;
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] mcand_q;
  logic [HILO_W-1:0] mplier_q;
  logic              neg_q;

  // Magnitude of an operand; signed operands are folded to unsigned and the
  // sign is reapplied on the final product.
  function automatic logic [HILO_W-1:0] op_mag(input logic [HILO_W-1:0] v,
                                                input logic is_signed);
    return (is_signed && v[HILO_W-1]) ? (~v + 1'b1) : v;
  endfunction

  // Control FSM: IDLE accepts, BUSY runs 32 steps, DONE presents the product.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MUL_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          done_q  <= 1'b0;
          count_q <= '0;
          if (start_i) state_q <= MUL_BUSY;
        end
        MUL_BUSY: begin
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q <= MUL_DONE;
            done_q  <= 1'b1;
          end
        end
        MUL_DONE: begin
          state_q <= MUL_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= MUL_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Shift-add datapath; no reset needed because the FSM gates every use.
  always_ff @(posedge clk_i) begin
    if (state_q == MUL_IDLE && start_i) begin
      mcand_q  <= {{HILO_W{1'b0}}, op_mag(a_i, signed_i)};
      mplier_q <= op_mag(b_i, signed_i);
      acc_q    <= '0;
      neg_q    <= signed_i & (a_i[HILO_W-1] ^ b_i[HILO_W-1]);
    end else if (state_q == MUL_BUSY) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  // Sign fix-up, stall request and done flag.
  always_comb begin
    product_o = neg_q ? (~acc_q + 1'b1) : acc_q;
    stall_o   = (state_q == MUL_IDLE && start_i) || (state_q == MUL_BUSY);
    done_o    = done_q;
  end
`else
  logic signed [PROD_W-1:0] a_sx;
  logic signed [PROD_W-1:0] b_sx;
  logic        [PROD_W-1:0] a_zx;
  logic        [PROD_W-1:0] b_zx;

  // Single-cycle product; result is consumed at the edge the MULT leaves.
  always_comb begin
    a_sx      = {{HILO_W{a_i[HILO_W-1]}}, a_i};
    b_sx      = {{HILO_W{b_i[HILO_W-1]}}, b_i};
    a_zx      = {{HILO_W{1'b0}}, a_i};
    b_zx      = {{HILO_W{1'b0}}, b_i};
    product_o = signed_i ? PROD_W'(a_sx * b_sx) : PROD_W'(a_zx * b_zx);
    done_o    = start_i;
    stall_o   = 1'b0;
  end
`endif

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Drives the data SRAM combinationally, owns
// the HI/LO registers and the MEM/WB register, and runs MULT/MULTU through
// mul_iter. Define ITERATIVE_MUL_EN for the multi-cycle multiplier that
// stalls upstream; the default build multiplies in one cycle with no stall.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [HILO_W-1:0] HILO_INIT = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemEn_EX_MEM,
  input  logic        MemToReg_EX_MEM,
  input  logic [3:0]  MemWrite_EX_MEM,
  input  logic [3:0]  RegWrite_EX_MEM,
  input  logic [1:0]  MULT_EX_MEM,
  input  logic [1:0]  MFHL_EX_MEM,
  input  logic [1:0]  MTHL_EX_MEM,
  input  logic [4:0]  RegWaddr_EX_MEM,
  input  logic [31:0] ALUResult_EX_MEM,
  input  logic [31:0] MemWdata_EX_MEM,
  input  logic [31:0] PC_EX_MEM,
  input  logic [31:0] RegRdata1_EX_MEM,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic        MemToReg_MEM_WB,
  output logic [3:0]  RegWrite_MEM_WB,
  output logic [4:0]  RegWaddr_MEM_WB,
  output logic [31:0] ALUResult_MEM_WB,
  output logic [31:0] PC_MEM_WB,
  output logic        mem_stall
);

  logic              mult_valid;
  logic              mult_signed;
  logic              mul_done;
  logic              mul_stall;
  logic [PROD_W-1:0] mul_product;
  logic [HILO_W-1:0] hi_q, lo_q, hi_d, lo_d;
  logic [31:0]       alu_sel;

  // MULT=11 is not a multiply and is ignored.
  always_comb begin
    mult_valid  = (MULT_EX_MEM == MULT_OP_S) || (MULT_EX_MEM == MULT_OP_U);
    mult_signed = (MULT_EX_MEM == MULT_OP_S);
  end

  mul_iter u_mul (
`ifdef ITERATIVE_MUL_EN
    .clk_i     (clk),
    .rst_i     (reset),
`endif
    .start_i   (mult_valid),
    .signed_i  (mult_signed),
    .a_i       (RegRdata1_EX_MEM),
    .b_i       (MemWdata_EX_MEM),
    .product_o (mul_product),
    .done_o    (mul_done),
    .stall_o   (mul_stall)
  );

  // SRAM request straight from EX_MEM; writes are suppressed while frozen.
  always_comb begin
    mem_stall       = mul_stall;
    data_sram_en    = MemEn_EX_MEM;
    data_sram_wen   = mul_stall ? 4'b0000 : MemWrite_EX_MEM;
    data_sram_addr  = ALUResult_EX_MEM;
    data_sram_wdata = MemWdata_EX_MEM;
  end

  // MFHI/MFLO override the ALU result; MFHL=11 falls through as 00.
  always_comb begin
    case (MFHL_EX_MEM)
      MFHL_HI: alu_sel = hi_q;
      MFHL_LO: alu_sel = lo_q;
      default: alu_sel = ALUResult_EX_MEM;
    endcase
  end

  // HI/LO next state: a finished multiply wins, otherwise MTHI/MTLO.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mul_done) begin
      hi_d = mul_product[PROD_W-1:HILO_W];
      lo_d = mul_product[HILO_W-1:0];
    end else if (!mul_stall) begin
      if (MTHL_EX_MEM == MTHL_HI) hi_d = RegRdata1_EX_MEM;
      if (MTHL_EX_MEM == MTHL_LO) lo_d = RegRdata1_EX_MEM;
    end
  end

  // HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= HILO_INIT;
      lo_q <= HILO_INIT;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // MEM/WB register: bubble while stalled, multiplies never write the GPRs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemToReg_MEM_WB  <= 1'b0;
      RegWrite_MEM_WB  <= 4'b0000;
      RegWaddr_MEM_WB  <= 5'd0;
      ALUResult_MEM_WB <= 32'd0;
      PC_MEM_WB        <= 32'd0;
    end else if (mul_stall) begin
      MemToReg_MEM_WB  <= 1'b0;
      RegWrite_MEM_WB  <= 4'b0000;
      RegWaddr_MEM_WB  <= 5'd0;
      ALUResult_MEM_WB <= 32'd0;
      PC_MEM_WB        <= 32'd0;
    end else begin
      MemToReg_MEM_WB  <= MemToReg_EX_MEM;
      RegWrite_MEM_WB  <= mult_valid ? 4'b0000 : RegWrite_EX_MEM;
      RegWaddr_MEM_WB  <= RegWaddr_EX_MEM;
      ALUResult_MEM_WB <= alu_sel;
      PC_MEM_WB        <= PC_EX_MEM;
    end
  end

endmodule
